// File: rtl/dea_pkg.sv
// Shared types for the DEA return path: frame FSM states, byte handshake phases
// and the default payload buffer depth.
package dea_pkg;

    localparam int DEA_MAX_BYTES = 100;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        PAY,
        SUM
    } txState_t;

    typedef enum logic [1:0] {
        ISSUE,
        ACCEPT,
        DRAIN
    } hsPhase_t;

endpackage

// File: rtl/dea_byte_handshake.sv
// Moves one byte into UART_Sender: waits for the sender to be free, strobes Tx_Send
// once, then follows Tx_Busy high and low before reporting the byte done.
module dea_byte_handshake
    import dea_pkg::*;
(
    input  logic       Clk_100M,
    input  logic       Reset_n,
    input  logic       Go,
    input  logic [7:0] Byte_In,
    output logic       Ready,
    output logic       Byte_Done,
    output logic [7:0] Tx_Data,
    output logic       Tx_Send,
    input  logic       Tx_Busy
);

    hsPhase_t   phase, phaseNext;
    logic       active, activeNext;
    logic [7:0] dataNext;
    logic       sendNext;

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            phase   <= ISSUE;
            active  <= 1'b0;
            Tx_Data <= 8'h00;
            Tx_Send <= 1'b0;
        end else begin
            phase   <= phaseNext;
            active  <= activeNext;
            Tx_Data <= dataNext;
            Tx_Send <= sendNext;
        end
    end

    // Tx_Data is only reloaded when idle, so it is stable from issue until drain exits
    always_comb begin
        phaseNext  = phase;
        activeNext = active;
        dataNext   = Tx_Data;
        sendNext   = 1'b0;
        Byte_Done  = 1'b0;
        if (!active) begin
            if (Go) begin
                activeNext = 1'b1;
                dataNext   = Byte_In;
                if (!Tx_Busy) begin
                    sendNext  = 1'b1;
                    phaseNext = ACCEPT;
                end else begin
                    phaseNext = ISSUE;
                end
            end
        end else begin
            case (phase)
                ISSUE: begin
                    if (!Tx_Busy) begin
                        sendNext  = 1'b1;
                        phaseNext = ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (Tx_Busy) phaseNext = DRAIN;
                end
                DRAIN: begin
                    if (!Tx_Busy) begin
                        Byte_Done  = 1'b1;
                        activeNext = 1'b0;
                        phaseNext  = ISSUE;
                    end
                end
                default: phaseNext = ISSUE;
            endcase
        end
    end

    assign Ready = !active;

endmodule

// File: rtl/dea_frame_tx.sv
// Sends the buffered encrypted bytes to the PC as a frame: length byte, payload,
// then an optional XOR checksum byte.
module dea_frame_tx
    import dea_pkg::*;
#(
    parameter int MAX_BYTES     = DEA_MAX_BYTES,
    parameter int ADDR_W        = 7,
    parameter int SEND_CHECKSUM = 1
) (
    input  logic              Clk_100M,
    input  logic              Reset_n,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [7:0]        Wr_Data,
    input  logic              Start,
    input  logic [7:0]        Length,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        Tx_Data,
    output logic              Tx_Send,
    input  logic              Tx_Busy
);

    logic [7:0] mem [MAX_BYTES];
    logic [7:0] rdData;

    txState_t   state, stateNext;
    logic [7:0] lenReg, idx, sumReg;
    logic       loadFrame, idxInc, sumUpdate, finish;
    logic       hsGo, hsReady, hsDone;
    logic [7:0] hsByte;

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk_100M) begin
        if (Wr_En && !Busy && (32'(Wr_Addr) < MAX_BYTES))
            mem[Wr_Addr] <= Wr_Data;
        if (state == FETCH)
            rdData <= mem[ADDR_W'(idx)];
    end

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            lenReg <= 8'h00;
            idx    <= 8'h00;
            sumReg <= 8'h00;
            Done   <= 1'b0;
        end else begin
            state <= stateNext;
            Done  <= finish;
            if (loadFrame) begin
                lenReg <= (32'(Length) > MAX_BYTES) ? 8'(MAX_BYTES) : Length;
                idx    <= 8'h00;
                sumReg <= 8'h00;
            end else begin
                if (idxInc)    idx    <= idx + 8'd1;
                if (sumUpdate) sumReg <= sumReg ^ rdData;
            end
        end
    end

    // Every byte state hands its byte over once, then leaves on the handshake's done
    always_comb begin
        stateNext = state;
        loadFrame = 1'b0;
        idxInc    = 1'b0;
        sumUpdate = 1'b0;
        finish    = 1'b0;
        hsGo      = 1'b0;
        hsByte    = 8'h00;
        case (state)
            IDLE: begin
                if (Start) begin
                    loadFrame = 1'b1;
                    stateNext = HDR;
                end
            end
            HDR: begin
                hsGo   = hsReady;
                hsByte = lenReg;
                if (hsDone) begin
                    if (lenReg != 8'h00) begin
                        stateNext = FETCH;
                    end else if (SEND_CHECKSUM != 0) begin
                        stateNext = SUM;
                    end else begin
                        stateNext = IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            FETCH: stateNext = PAY;
            PAY: begin
                hsGo      = hsReady;
                hsByte    = rdData;
                sumUpdate = hsReady;
                if (hsDone) begin
                    idxInc = 1'b1;
                    if (({1'b0, idx} + 9'd1) < {1'b0, lenReg}) begin
                        stateNext = FETCH;
                    end else if (SEND_CHECKSUM != 0) begin
                        stateNext = SUM;
                    end else begin
                        stateNext = IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            SUM: begin
                hsGo   = hsReady;
                hsByte = sumReg;
                if (hsDone) begin
                    stateNext = IDLE;
                    finish    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    dea_byte_handshake uHandshake (
        .Clk_100M (Clk_100M),
        .Reset_n  (Reset_n),
        .Go       (hsGo),
        .Byte_In  (hsByte),
        .Ready    (hsReady),
        .Byte_Done(hsDone),
        .Tx_Data  (Tx_Data),
        .Tx_Send  (Tx_Send),
        .Tx_Busy  (Tx_Busy)
    );

endmodule

// File: tb/tb_dea_frame_tx.sv
// Scoreboard bench for dea_frame_tx: a UART_Sender model per instance pops the
// expected line bytes as each Tx_Send is seen.
module tb_dea_frame_tx;

    localparam int MAXB = 100;

    logic       Clk_100M = 1'b0;
    logic       Reset_n;
    logic       Wr_En;
    logic [6:0] Wr_Addr;
    logic [7:0] Wr_Data;
    logic       Start, StartNs;
    logic [7:0] Length;
    logic       Busy, Done, Tx_Send, Tx_Busy;
    logic [7:0] Tx_Data;
    logic       BusyNs, DoneNs, Tx_SendNs, Tx_BusyNs;
    logic [7:0] Tx_DataNs;

    always #5 Clk_100M = ~Clk_100M;

    dea_frame_tx #(.MAX_BYTES(MAXB), .ADDR_W(7), .SEND_CHECKSUM(1)) dut (
        .Clk_100M(Clk_100M), .Reset_n(Reset_n),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Start(Start), .Length(Length),
        .Busy(Busy), .Done(Done),
        .Tx_Data(Tx_Data), .Tx_Send(Tx_Send), .Tx_Busy(Tx_Busy)
    );

    dea_frame_tx #(.MAX_BYTES(MAXB), .ADDR_W(7), .SEND_CHECKSUM(0)) dutNoSum (
        .Clk_100M(Clk_100M), .Reset_n(Reset_n),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Start(StartNs), .Length(Length),
        .Busy(BusyNs), .Done(DoneNs),
        .Tx_Data(Tx_DataNs), .Tx_Send(Tx_SendNs), .Tx_Busy(Tx_BusyNs)
    );

    int         checkCount = 0;
    int         errorCount = 0;
    logic [7:0] shadow [MAXB];
    logic [7:0] expQ[$];
    logic [7:0] nsQ[$];

    int         sendCount = 0, doneCount = 0, busyCnt = 0;
    int         nsSendCount = 0, nsDoneCount = 0, nsBusyCnt = 0;
    logic       prevSend = 1'b0, nsPrevSend = 1'b0;
    logic [7:0] lastByte = 8'h00, nsLastByte = 8'h00;
    logic       forceBusy = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // UART_Sender model for the checksum instance: 10 busy cycles per byte
    always @(negedge Clk_100M) begin
        if (Tx_Send) begin
            checkOutput("sendWhileBusy", 32'(Tx_Busy), 0);
            checkOutput("sendWidth", 32'(prevSend), 0);
            sendCount++;
            checkOutput("queueNonEmpty", 32'(expQ.size() != 0), 1);
            if (expQ.size() != 0) checkOutput("txByte", 32'(Tx_Data), 32'(expQ.pop_front()));
            lastByte = Tx_Data;
            busyCnt  = 10;
        end else if (busyCnt > 0) begin
            if (busyCnt == 1) checkOutput("txDataHold", 32'(Tx_Data), 32'(lastByte));
            busyCnt--;
        end
        prevSend = Tx_Send;
        if (Done) doneCount++;
        Tx_Busy = (busyCnt > 0) || forceBusy;
    end

    always @(negedge Clk_100M) begin
        if (Tx_SendNs) begin
            checkOutput("nsSendWhileBusy", 32'(Tx_BusyNs), 0);
            checkOutput("nsSendWidth", 32'(nsPrevSend), 0);
            nsSendCount++;
            checkOutput("nsQueueNonEmpty", 32'(nsQ.size() != 0), 1);
            if (nsQ.size() != 0) checkOutput("nsTxByte", 32'(Tx_DataNs), 32'(nsQ.pop_front()));
            nsLastByte = Tx_DataNs;
            nsBusyCnt  = 10;
        end else if (nsBusyCnt > 0) begin
            if (nsBusyCnt == 1) checkOutput("nsTxDataHold", 32'(Tx_DataNs), 32'(nsLastByte));
            nsBusyCnt--;
        end
        nsPrevSend = Tx_SendNs;
        if (DoneNs) nsDoneCount++;
        Tx_BusyNs = (nsBusyCnt > 0);
    end

    task automatic writeMem(input int addr, input logic [7:0] data);
        @(negedge Clk_100M);
        Wr_En   = 1'b1;
        Wr_Addr = 7'(addr);
        Wr_Data = data;
        shadow[addr] = data;
        @(negedge Clk_100M);
        Wr_En = 1'b0;
    endtask

    // Pushes the expected frame for the bench's memory image, then pulses Start
    task automatic applyStimulus(input int len, input bit toNs, output int nBytes);
        int         clamp;
        logic [7:0] s;
        clamp = (len > MAXB) ? MAXB : len;
        s = 8'h00;
        if (toNs) nsQ.push_back(8'(clamp)); else expQ.push_back(8'(clamp));
        for (int i = 0; i < clamp; i++) begin
            s ^= shadow[i];
            if (toNs) nsQ.push_back(shadow[i]); else expQ.push_back(shadow[i]);
        end
        if (!toNs) expQ.push_back(s);
        nBytes = clamp + (toNs ? 1 : 2);
        @(negedge Clk_100M);
        Length = 8'(len);
        if (toNs) StartNs = 1'b1; else Start = 1'b1;
        @(negedge Clk_100M);
        Start   = 1'b0;
        StartNs = 1'b0;
        checkOutput(toNs ? "nsBusyAfterStart" : "busyAfterStart", 32'(toNs ? BusyNs : Busy), 1);
    endtask

    task automatic waitDone(input bit toNs, input int budget);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            @(negedge Clk_100M);
            n++;
            got = toNs ? DoneNs : Done;
        end
        checkOutput("doneTimeout", 32'(got), 1);
        checkOutput("busyAtDone", 32'(toNs ? BusyNs : Busy), 0);
    endtask

    task automatic runFrame(input int len, input bit toNs);
        int nBytes, sends0, dones0;
        sends0 = toNs ? nsSendCount : sendCount;
        dones0 = toNs ? nsDoneCount : doneCount;
        applyStimulus(len, toNs, nBytes);
        waitDone(toNs, (nBytes + 2) * 20 + 100);
        repeat (3) @(negedge Clk_100M);
        checkOutput("frameSends", 32'((toNs ? nsSendCount : sendCount) - sends0), 32'(nBytes));
        checkOutput("donePulses", 32'((toNs ? nsDoneCount : doneCount) - dones0), 1);
        checkOutput("queueEmpty", 32'(toNs ? nsQ.size() : expQ.size()), 0);
    endtask

    initial begin
        int nBytes, sends0, n;
        Reset_n = 1'b0;
        Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
        Start = 1'b0; StartNs = 1'b0; Length = '0;
        repeat (3) @(negedge Clk_100M);
        checkOutput("resetBusy", 32'(Busy), 0);
        checkOutput("resetDone", 32'(Done), 0);
        checkOutput("resetTxSend", 32'(Tx_Send), 0);
        checkOutput("resetTxData", 32'(Tx_Data), 0);
        Reset_n = 1'b1;

        writeMem(0, 8'h41);
        writeMem(1, 8'h42);
        writeMem(2, 8'h43);
        for (int i = 3; i < MAXB; i++) writeMem(i, 8'(i * 7 + 3));

        $display("[TB] basic frame");
        sends0 = sendCount;
        applyStimulus(3, 1'b0, nBytes);
        @(negedge Clk_100M);
        checkOutput("hdrSendTiming", 32'(Tx_Send), 1);
        waitDone(1'b0, 400);
        repeat (3) @(negedge Clk_100M);
        checkOutput("basicSends", 32'(sendCount - sends0), 5);
        checkOutput("basicQueueEmpty", 32'(expQ.size()), 0);

        $display("[TB] zero length");
        runFrame(0, 1'b0);
        runFrame(0, 1'b1);

        $display("[TB] clamp");
        runFrame(200, 1'b0);

        $display("[TB] inputs while busy");
        sends0 = sendCount;
        applyStimulus(3, 1'b0, nBytes);
        repeat (30) @(negedge Clk_100M);
        Start = 1'b1; Length = 8'd5;
        Wr_En = 1'b1; Wr_Addr = 7'd1; Wr_Data = 8'hFF;
        checkOutput("busyDuringIgnore", 32'(Busy), 1);
        @(negedge Clk_100M);
        Start = 1'b0; Wr_En = 1'b0;
        waitDone(1'b0, 400);
        repeat (3) @(negedge Clk_100M);
        checkOutput("ignoreSends", 32'(sendCount - sends0), 5);
        runFrame(3, 1'b0);

        $display("[TB] handshake abuse");
        forceBusy = 1'b1;
        sends0 = sendCount;
        applyStimulus(3, 1'b0, nBytes);
        repeat (50) @(negedge Clk_100M);
        checkOutput("noSendWhileHeld", 32'(sendCount - sends0), 0);
        forceBusy = 1'b0;
        waitDone(1'b0, 400);
        repeat (3) @(negedge Clk_100M);
        checkOutput("abuseSends", 32'(sendCount - sends0), 5);

        $display("[TB] reset mid-frame");
        sends0 = sendCount;
        applyStimulus(3, 1'b0, nBytes);
        n = 0;
        while ((sendCount - sends0) < 3 && n < 400) begin
            @(negedge Clk_100M);
            n++;
        end
        checkOutput("reachPayIdx1", 32'(sendCount - sends0), 3);
        repeat (3) @(negedge Clk_100M);
        #2 Reset_n = 1'b0;
        lastByte = 8'h00;
        #1;
        checkOutput("rstBusy", 32'(Busy), 0);
        checkOutput("rstTxSend", 32'(Tx_Send), 0);
        checkOutput("rstDone", 32'(Done), 0);
        expQ.delete();
        repeat (5) @(negedge Clk_100M);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clk_100M);
        checkOutput("noSendAfterReset", 32'(sendCount - sends0), 3);
        runFrame(3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
